// File: rtl/exc_ctrl.sv
// Exception/interrupt control at the M/WB boundary: resolves exception priority,
// synchronizes hardware interrupts and issues one commit pulse plus flush/redirect to CP0.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        stall_m,
  input  logic [31:0] pc_m,
  input  logic        indelayslot_m,
  input  logic [31:0] mem_addr_m,
  input  logic        adel_if_m,
  input  logic        ri_m,
  input  logic        sys_m,
  input  logic        bp_m,
  input  logic        ov_m,
  input  logic        adel_ld_m,
  input  logic        ades_m,
  input  logic        eret_m,
  input  logic [5:0]  ext_int,
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  output logic [5:0]  hw_ip,
  output logic        cp0_en,
  output logic [5:0]  cp0_exctype,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_indelayslot,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] newpc
);

  localparam logic [5:0] EXC_INT  = 6'h00;
  localparam logic [5:0] EXC_ADEL = 6'h04;
  localparam logic [5:0] EXC_ADES = 6'h05;
  localparam logic [5:0] EXC_SYS  = 6'h08;
  localparam logic [5:0] EXC_BP   = 6'h09;
  localparam logic [5:0] EXC_RI   = 6'h0a;
  localparam logic [5:0] EXC_OV   = 6'h0c;
  localparam logic [5:0] EXC_ERET = 6'h0e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [5:0]  sync_q [SYNC_STAGES];
  logic        int_req;
  logic        any_flag;
  logic        take;
  logic [5:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        unused_cp0_bits;

  assign unused_cp0_bits = ^{status[31:16], status[7:2], cause[31:10], cause[7:0]};

  // Interrupt synchronizer: plain flop chain, all stages cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_ip = sync_q[SYNC_STAGES-1];

  assign int_req = status[0] & ~status[1] &
                   (|((hw_ip & status[15:10]) | (cause[9:8] & status[9:8])));

  assign any_flag = adel_if_m | ri_m | sys_m | bp_m | ov_m | adel_ld_m | ades_m | eret_m;

  assign take = (state_q == ST_IDLE) & valid_m & ~stall_m & (int_req | any_flag);

  // Priority resolve; the bad address follows whichever cause actually won.
  always_comb begin
    exc_code     = EXC_ERET;
    exc_badvaddr = '0;
    if (int_req) begin
      exc_code = EXC_INT;
    end else if (adel_if_m) begin
      exc_code     = EXC_ADEL;
      exc_badvaddr = pc_m;
    end else if (ri_m) begin
      exc_code = EXC_RI;
    end else if (sys_m) begin
      exc_code = EXC_SYS;
    end else if (bp_m) begin
      exc_code = EXC_BP;
    end else if (ov_m) begin
      exc_code = EXC_OV;
    end else if (adel_ld_m) begin
      exc_code     = EXC_ADEL;
      exc_badvaddr = mem_addr_m;
    end else if (ades_m) begin
      exc_code     = EXC_ADES;
      exc_badvaddr = mem_addr_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (take) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cp0_en   = 1'b0;
    flush    = 1'b0;
    redirect = 1'b0;
    case (state_q)
      ST_COMMIT: begin
        cp0_en   = 1'b1;
        flush    = 1'b1;
        redirect = 1'b1;
      end
      ST_SETTLE: flush = 1'b1;
      default: ;
    endcase
  end

  // Commit payload is captured at take and held until the next take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cp0_exctype     <= '0;
      cp0_pc          <= '0;
      cp0_badvaddr    <= '0;
      cp0_indelayslot <= 1'b0;
      newpc           <= '0;
    end else if (take) begin
      cp0_exctype     <= exc_code;
      cp0_pc          <= pc_m;
      cp0_badvaddr    <= exc_badvaddr;
      cp0_indelayslot <= indelayslot_m;
      newpc           <= (exc_code == EXC_ERET) ? epc : EXC_VECTOR;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed scoreboard bench for exc_ctrl: expected commits are queued by the
// stimulus process and popped by a monitor whenever cp0_en is seen.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_m, stall_m, indelayslot_m;
  logic [31:0] pc_m, mem_addr_m;
  logic        adel_if_m, ri_m, sys_m, bp_m, ov_m, adel_ld_m, ades_m, eret_m;
  logic [5:0]  ext_int;
  logic [31:0] status, cause, epc;
  logic [5:0]  hw_ip;
  logic        cp0_en;
  logic [5:0]  cp0_exctype;
  logic [31:0] cp0_pc, cp0_badvaddr;
  logic        cp0_indelayslot;
  logic        flush, redirect;
  logic [31:0] newpc;

  // {exctype, pc, badvaddr, indelayslot, newpc}
  logic [102:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .stall_m(stall_m), .pc_m(pc_m),
    .indelayslot_m(indelayslot_m), .mem_addr_m(mem_addr_m),
    .adel_if_m(adel_if_m), .ri_m(ri_m), .sys_m(sys_m), .bp_m(bp_m), .ov_m(ov_m),
    .adel_ld_m(adel_ld_m), .ades_m(ades_m), .eret_m(eret_m), .ext_int(ext_int),
    .status(status), .cause(cause), .epc(epc), .hw_ip(hw_ip), .cp0_en(cp0_en),
    .cp0_exctype(cp0_exctype), .cp0_pc(cp0_pc), .cp0_badvaddr(cp0_badvaddr),
    .cp0_indelayslot(cp0_indelayslot), .flush(flush), .redirect(redirect), .newpc(newpc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_flags();
    valid_m = 0; stall_m = 0; indelayslot_m = 0;
    adel_if_m = 0; ri_m = 0; sys_m = 0; bp_m = 0; ov_m = 0;
    adel_ld_m = 0; ades_m = 0; eret_m = 0;
  endtask

  task automatic push_exp(input logic [5:0] code, input logic [31:0] pc,
                          input logic [31:0] bad, input logic ds, input logic [31:0] npc);
    exp_q.push_back({code, pc, bad, ds, npc});
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_cp0_en"}, {31'd0, cp0_en}, 32'd0);
    check({tag, "_flush"}, {31'd0, flush}, 32'd0);
    check({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
  endtask

  // Monitor: every cp0_en pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && cp0_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_commit: got exctype %h pc %h, expected no commit", cp0_exctype, cp0_pc);
      end else begin
        logic [102:0] e;
        e = exp_q.pop_front();
        check("mon_exctype", {26'd0, cp0_exctype}, {26'd0, e[102:97]});
        check("mon_pc", cp0_pc, e[96:65]);
        check("mon_badvaddr", cp0_badvaddr, e[64:33]);
        check("mon_indelayslot", {31'd0, cp0_indelayslot}, {31'd0, e[32]});
        check("mon_newpc", newpc, e[31:0]);
        check("mon_flush", {31'd0, flush}, 32'd1);
        check("mon_redirect", {31'd0, redirect}, 32'd1);
      end
    end
  end

  initial begin
    clr_flags();
    pc_m = 0; mem_addr_m = 0; status = 0; cause = 0; epc = 0;
    ext_int = 6'h3f; ri_m = 1; valid_m = 1;

    // Reset held with active inputs: everything stays zero.
    repeat (3) @(negedge clk);
    check_idle_outs("rst");
    check("rst_hw_ip", {26'd0, hw_ip}, 32'd0);
    check("rst_exctype", {26'd0, cp0_exctype}, 32'd0);
    check("rst_newpc", newpc, 32'd0);
    check("rst_cp0_pc", cp0_pc, 32'd0);
    clr_flags();
    rst = 1;
    @(negedge clk);
    check("sync_edge1", {26'd0, hw_ip}, 32'd0);
    @(negedge clk);
    check("sync_edge2", {26'd0, hw_ip}, 32'h3f);
    ext_int = 0;
    repeat (3) @(negedge clk);
    check_idle_outs("no_take_without_ie");

    // Multiple flags: RI wins over SYS and OV.
    valid_m = 1; pc_m = 32'h8000_0100; ri_m = 1; sys_m = 1; ov_m = 1;
    push_exp(6'h0a, 32'h8000_0100, 32'd0, 1'b0, VEC);
    @(negedge clk);
    clr_flags();
    check("multi_t1_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    check("multi_t2_flush", {31'd0, flush}, 32'd1);
    check("multi_t2_cp0_en", {31'd0, cp0_en}, 32'd0);
    check("multi_t2_redirect", {31'd0, redirect}, 32'd0);
    @(negedge clk);
    check("multi_t3_flush", {31'd0, flush}, 32'd0);
    check("hold_exctype", {26'd0, cp0_exctype}, 32'h0a);
    check("hold_newpc", newpc, VEC);

    // Load address fault in a delay slot.
    valid_m = 1; pc_m = 32'h8000_0200; adel_ld_m = 1; mem_addr_m = 32'h0000_0003; indelayslot_m = 1;
    push_exp(6'h04, 32'h8000_0200, 32'h0000_0003, 1'b1, VEC);
    @(negedge clk);
    clr_flags();
    repeat (2) @(negedge clk);

    // Store fault beneath overflow: OV wins, badvaddr 0.
    valid_m = 1; pc_m = 32'h8000_0280; ov_m = 1; ades_m = 1; mem_addr_m = 32'h0000_0006;
    push_exp(6'h0c, 32'h8000_0280, 32'd0, 1'b0, VEC);
    @(negedge clk);
    clr_flags();
    repeat (2) @(negedge clk);

    // Interrupt: bubble and stall block it, release of stall takes it.
    ext_int = 6'b000100; status = 32'h0000_1001;
    repeat (3) @(negedge clk);
    check("int_sync", {26'd0, hw_ip}, 32'h04);
    @(negedge clk);
    check_idle_outs("int_bubble");
    valid_m = 1; stall_m = 1; pc_m = 32'h8000_0300;
    @(negedge clk);
    check_idle_outs("int_stall1");
    @(negedge clk);
    check_idle_outs("int_stall2");
    stall_m = 0;
    push_exp(6'h00, 32'h8000_0300, 32'd0, 1'b0, VEC);
    @(negedge clk);
    clr_flags();
    ext_int = 0; status = 0;
    check("int_t1_redirect", {31'd0, redirect}, 32'd1);
    repeat (4) @(negedge clk);

    // ERET, then a BP flag during COMMIT/SETTLE that must be ignored.
    valid_m = 1; pc_m = 32'h8000_0400; eret_m = 1; epc = 32'h8000_2000;
    push_exp(6'h0e, 32'h8000_0400, 32'd0, 1'b0, 32'h8000_2000);
    @(negedge clk);
    clr_flags();
    valid_m = 1; pc_m = 32'h8000_0404; bp_m = 1;
    @(negedge clk);
    check("settle_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    clr_flags();
    check_idle_outs("bp_ignored");
    repeat (2) @(negedge clk);
    check_idle_outs("bp_ignored_later");

    // Reset during COMMIT aborts immediately.
    valid_m = 1; pc_m = 32'h8000_0500; sys_m = 1;
    push_exp(6'h08, 32'h8000_0500, 32'd0, 1'b0, VEC);
    @(negedge clk);
    clr_flags();
    #2 rst = 0;
    #1;
    check_idle_outs("midrst");
    check("midrst_exctype", {26'd0, cp0_exctype}, 32'd0);
    check("midrst_newpc", newpc, 32'd0);
    check("midrst_state", {30'd0, dut.state_q}, 32'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("postrst_state", {30'd0, dut.state_q}, 32'd0);
    check_idle_outs("postrst");
    repeat (2) @(negedge clk);
    check_idle_outs("postrst_later");

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
